// File: rtl/stream_wrr_scheduler_4ports_if.sv
// 8-bit stb/ack/last stream link: the master drives beats, the slave returns ack.
interface stream_wrr_scheduler_4ports_if;
  logic       stb;
  logic       ack;
  logic [7:0] d;
  logic       last;

  modport master (output stb, output d, output last, input ack);
  modport slave  (input stb, input d, input last, output ack);
endinterface

// File: rtl/stream_wrr_scheduler_4ports.sv
// Packet-atomic weighted round-robin mux of four 8-bit packet streams onto one sink,
// with per-port enable, per-port packet credit and a mid-packet stall watchdog.
module stream_wrr_scheduler_4ports #(
  parameter int unsigned STALL_TIMEOUT = 256,
  parameter int unsigned TW            = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [3:0]                    port_en,
  input  logic [15:0]                   weight,
  stream_wrr_scheduler_4ports_if.slave  sink0,
  stream_wrr_scheduler_4ports_if.slave  sink1,
  stream_wrr_scheduler_4ports_if.slave  sink2,
  stream_wrr_scheduler_4ports_if.slave  sink3,
  stream_wrr_scheduler_4ports_if.master source,
  output logic                          grant_valid,
  output logic [1:0]                    grant_id,
  output logic                          pkt_done,
  output logic                          abort
);
  localparam logic [0:0]    ST_IDLE     = 1'b0;
  localparam logic [0:0]    ST_BUSY     = 1'b1;
  localparam bit            WD_ON       = (STALL_TIMEOUT != 0);
  localparam logic [TW-1:0] STALL_LIMIT = TW'(STALL_TIMEOUT - 1);

  logic [0:0]    state_r;
  logic [1:0]    grant_id_r;
  logic [3:0]    credit_r;
  logic [TW-1:0] stall_cnt_r;
  logic          pkt_done_r;
  logic          abort_r;

  logic [3:0] stb_s, last_s, elig_s, ack_s;
  logic [7:0] d_s [4];
  logic       busy_s, cur_stb_s, cur_last_s, last_xfer_s;
  logic [7:0] cur_d_s;
  logic       pick_found_s, pick_load_s;
  logic [1:0] pick_id_s, cand_s;
  logic [3:0] pick_w_s, load_credit_s;

  assign stb_s  = {sink3.stb, sink2.stb, sink1.stb, sink0.stb};
  assign last_s = {sink3.last, sink2.last, sink1.last, sink0.last};
  assign d_s[0] = sink0.d;
  assign d_s[1] = sink1.d;
  assign d_s[2] = sink2.d;
  assign d_s[3] = sink3.d;
  assign sink0.ack = ack_s[0];
  assign sink1.ack = ack_s[1];
  assign sink2.ack = ack_s[2];
  assign sink3.ack = ack_s[3];

  assign busy_s      = (state_r == ST_BUSY);
  assign cur_stb_s   = stb_s[grant_id_r];
  assign cur_last_s  = last_s[grant_id_r];
  assign cur_d_s     = d_s[grant_id_r];
  assign last_xfer_s = busy_s & cur_stb_s & source.ack & cur_last_s;

  assign grant_valid = busy_s;
  assign grant_id    = grant_id_r;
  assign pkt_done    = pkt_done_r;
  assign abort       = abort_r;

  // Output path: granted port is wired straight through while a packet is open
  always_comb begin
    ack_s        = 4'b0000;
    source.stb   = 1'b0;
    source.d     = 8'h00;
    source.last  = 1'b0;
    if (busy_s) begin
      source.stb         = cur_stb_s;
      source.d           = cur_d_s;
      source.last        = cur_last_s;
      ack_s[grant_id_r]  = source.ack;
    end else begin
      ack_s = 4'b0000;
    end
  end

  // Arbitration: keep the current port while it has credit, else rotate from grant_id+1.
  // Scanning offsets 4..1 with last-match-wins leaves the nearest eligible port selected.
  always_comb begin
    elig_s       = stb_s & port_en;
    pick_found_s = 1'b0;
    pick_load_s  = 1'b0;
    pick_id_s    = grant_id_r;
    cand_s       = grant_id_r;
    if ((credit_r != 4'd0) && elig_s[grant_id_r]) begin
      pick_found_s = 1'b1;
    end else begin
      for (int k = 4; k >= 1; k--) begin
        cand_s       = grant_id_r + 2'(k);
        pick_id_s    = elig_s[cand_s] ? cand_s : pick_id_s;
        pick_found_s = pick_found_s | elig_s[cand_s];
      end
      pick_load_s = pick_found_s;
    end
    pick_w_s      = weight[{pick_id_s, 2'b00} +: 4];
    load_credit_s = (pick_w_s == 4'd0) ? 4'd1 : pick_w_s;
  end

  // Scheduler state, credit, watchdog and event pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      grant_id_r  <= 2'd3;
      credit_r    <= 4'd0;
      stall_cnt_r <= '0;
      pkt_done_r  <= 1'b0;
      abort_r     <= 1'b0;
    end else begin
      pkt_done_r <= 1'b0;
      abort_r    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          stall_cnt_r <= '0;
          if (pick_found_s) begin
            state_r    <= ST_BUSY;
            grant_id_r <= pick_id_s;
            credit_r   <= pick_load_s ? load_credit_s : credit_r;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (last_xfer_s) begin
            state_r     <= ST_IDLE;
            pkt_done_r  <= 1'b1;
            stall_cnt_r <= '0;
            credit_r    <= (port_en[grant_id_r] && (credit_r != 4'd0)) ? (credit_r - 4'd1) : 4'd0;
          end else if (cur_stb_s) begin
            // a presented beat (accepted or backpressured) proves the source is alive
            stall_cnt_r <= '0;
            credit_r    <= port_en[grant_id_r] ? credit_r : 4'd0;
          end else if (WD_ON && (stall_cnt_r == STALL_LIMIT)) begin
            state_r     <= ST_IDLE;
            abort_r     <= 1'b1;
            credit_r    <= 4'd0;
            stall_cnt_r <= '0;
          end else begin
            stall_cnt_r <= stall_cnt_r + TW'(1);
            credit_r    <= port_en[grant_id_r] ? credit_r : 4'd0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end
endmodule
